// File: rtl/aes_out_serializer.sv
// AES output serializer: captures each 128-bit AES result block on the rising
// edge of its valid into a small block FIFO, then streams the head block out
// as WORD_W-bit words, most-significant word first, over valid/ready.
// Blocks arriving while the FIFO is full (with no pop that cycle) are dropped
// and flagged by a sticky overflow bit.
module aes_out_serializer #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                         AES_clk,
  input  logic                         AES_rst,
  input  logic                         AES_data_out_valid,
  input  logic [127:0]                 AES_data_out,
  output logic                         m_valid,
  output logic [WORD_W-1:0]            m_data,
  output logic                         m_last,
  input  logic                         m_ready,
  output logic                         ovf,
  input  logic                         clr_ovf,
  output logic [$clog2(DEPTH+1)-1:0]   buf_count
);

  localparam int NUM_WORDS = 128 / WORD_W;
  localparam int IDX_W     = $clog2(NUM_WORDS);
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = $clog2(DEPTH + 1);

  logic [127:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [IDX_W-1:0] r_idx;
  logic             r_prev_valid;
  logic             r_ovf;

  logic                              w_capture;
  logic                              w_xfer;
  logic                              w_pop;
  logic                              w_full;
  logic                              w_accept;
  logic                              w_drop;
  logic                              w_last_idx;
  logic [NUM_WORDS-1:0][WORD_W-1:0]  w_words;

  // Pointer increment that wraps modulo DEPTH (DEPTH need not be a power of 2).
  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_capture  = AES_data_out_valid & ~r_prev_valid;
  assign w_last_idx = (r_idx == IDX_W'(NUM_WORDS - 1));
  assign w_xfer     = m_valid & m_ready;
  assign w_pop      = w_xfer & w_last_idx;
  assign w_full     = (r_count == CNT_W'(DEPTH));
  // A pop in the same cycle frees the slot, so a capture into a full FIFO is
  // still accepted when the head's last word leaves.
  assign w_accept   = w_capture & (~w_full | w_pop);
  assign w_drop     = w_capture & w_full & ~w_pop;

  // Outputs depend only on registered state; m_ready never reaches them.
  assign w_words   = r_mem[r_rd_ptr];
  assign m_valid   = (r_count != '0);
  assign m_data    = m_valid ? w_words[IDX_W'(NUM_WORDS - 1) - r_idx] : '0;
  assign m_last    = m_valid & w_last_idx;
  assign ovf       = r_ovf;
  assign buf_count = r_count;

  // Block storage: written at the tail on an accepted capture.
  always_ff @(posedge AES_clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= AES_data_out;
  end

  // Valid-edge detect, FIFO pointers/count, word index and sticky overflow.
  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      r_prev_valid <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_idx        <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_prev_valid <= AES_data_out_valid;
      if (w_accept) r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop)    r_rd_ptr <= f_inc(r_rd_ptr);
      if (w_xfer)   r_idx    <= w_last_idx ? '0 : r_idx + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_out_serializer.sv
// Bench for aes_out_serializer: directed scenarios followed by a random phase,
// all checked every cycle against a queue-of-blocks reference model.
module tb_aes_out_serializer;

  localparam int WORD_W    = 32;
  localparam int DEPTH     = 2;
  localparam int NUM_WORDS = 128 / WORD_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [127:0]  din;
  logic          ready;
  logic          clr;
  logic          m_valid;
  logic [31:0]   m_data;
  logic          m_last;
  logic          ovf;
  logic [1:0]    buf_count;

  aes_out_serializer #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
    .AES_clk(clk), .AES_rst(rst), .AES_data_out_valid(valid), .AES_data_out(din),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(ready),
    .ovf(ovf), .clr_ovf(clr), .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  // Reference model: list of held blocks, position inside the head block,
  // last-seen valid, sticky overflow.
  logic [127:0] mq[$];
  int           midx;
  bit           mpv;
  bit           movf;
  logic [31:0]  got[$];
  int           npass = 0;
  int           ntot  = 0;
  int           nfail = 0;
  int           peak;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    mq.delete(); midx = 0; mpv = 0; movf = 0;
  endtask

  task automatic compare();
    bit          ev;
    logic [31:0] ed;
    ev = (mq.size() != 0);
    ed = ev ? 32'(mq[0] >> (128 - (midx + 1) * WORD_W)) : 32'h0;
    chk("m_valid",   m_valid,   ev);
    chk("m_data",    m_data,    ed);
    chk("m_last",    m_last,    ev && (midx == NUM_WORDS - 1));
    chk("buf_count", buf_count, mq.size());
    chk("ovf",       ovf,       movf);
  endtask

  // Advance one clock: update the model from the current inputs, clock, check.
  task automatic step();
    bit cap, pop, drop;
    int sz;
    if (m_valid && ready && !rst) got.push_back(m_data);
    if (rst) mreset();
    else begin
      sz = mq.size();
      cap = valid && !mpv;
      pop = 0;
      if (sz != 0 && ready) begin
        if (midx == NUM_WORDS - 1) begin
          pop = 1; void'(mq.pop_front()); midx = 0;
        end else midx++;
      end
      drop = cap && (sz == DEPTH) && !pop;
      if (cap && !drop) mq.push_back(din);
      if (drop) movf = 1;
      else if (clr) movf = 0;
      mpv = valid;
    end
    @(posedge clk); #1;
    compare();
    if (buf_count > peak) peak = buf_count;
  endtask

  task automatic pulse(input logic [127:0] d);
    din = d; valid = 1'b1; step();
    valid = 1'b0; step();
  endtask

  logic [31:0] bw [4] = '{32'h3925841d, 32'h02dc09fb, 32'hdc118597, 32'h196a0b32};
  logic [127:0] blk_d;

  initial begin
    rst = 1'b1; valid = 1'b0; din = '0; ready = 1'b0; clr = 1'b0;
    mreset();
    #2 compare();
    step(); step();
    rst = 1'b0;
    step();

    // Basic: one block, MS word first, one word per cycle.
    got.delete(); ready = 1'b1;
    pulse(128'h3925841d_02dc09fb_dc118597_196a0b32);
    repeat (4) step();
    chk("basic_words", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("basic_word", got[i], bw[i]);
    chk("basic_idle_valid", m_valid, 1'b0);

    // Long valid: one capture for 10 high cycles.
    got.delete(); peak = 0;
    din = 128'hcafef00d_12345678_9abcdef0_0badbeef; valid = 1'b1;
    repeat (10) step();
    valid = 1'b0; repeat (3) step();
    chk("long_words", got.size(), 4);
    chk("long_peak", peak, 1);

    // Back-pressure pattern within one block.
    got.delete(); ready = 1'b0;
    pulse(128'h11111111_22222222_33333333_44444444);
    foreach (bw[i]) begin end
    begin
      bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};
      for (int i = 0; i < 7; i++) begin ready = pat[i]; step(); end
    end
    chk("bp_words", got.size(), 4);
    if (got.size() == 4) chk("bp_last", got[3], 32'h44444444);
    chk("bp_empty", buf_count, 0);

    // Overflow: three captures into a 2-deep FIFO with no drain.
    got.delete(); ready = 1'b0;
    pulse(128'h1); pulse(128'h2); pulse(128'h3);
    chk("ovf_set", ovf, 1'b1);
    chk("ovf_count", buf_count, 2);
    ready = 1'b1; repeat (9) step();
    chk("ovf_words", got.size(), 8);
    if (got.size() == 8) begin
      chk("ovf_A", got[3], 32'h1);
      chk("ovf_B", got[7], 32'h2);
    end
    clr = 1'b1; step(); clr = 1'b0; step();
    chk("ovf_clr", ovf, 1'b0);

    // Full FIFO, head's last word leaves as D is captured.
    got.delete(); ready = 1'b0;
    pulse(128'hA); pulse(128'hB);
    ready = 1'b1; repeat (3) step();
    blk_d = 128'hdddddddd_eeeeeeee_ffffffff_0000000d;
    din = blk_d; valid = 1'b1; step();
    chk("fpc_ovf", ovf, 1'b0);
    chk("fpc_count", buf_count, 2);
    valid = 1'b0; repeat (9) step();
    chk("fpc_words", got.size(), 12);
    if (got.size() == 12) chk("fpc_D", got[11], 32'h0000000d);

    // Asynchronous reset after two words of a block.
    got.delete(); ready = 1'b1;
    pulse(128'h01020304_05060708_090a0b0c_0d0e0f10);
    step();
    rst = 1'b1; #1;
    mreset();
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_count", buf_count, 0);
    step();
    rst = 1'b0;
    din = 128'hfeedface_00000000_11111111_22222222; valid = 1'b1; step();
    chk("rst_first", m_data, din[127:96]);
    valid = 1'b0; repeat (4) step();

    // Random phase.
    for (int n = 0; n < 600; n++) begin
      if (!valid) din = {$urandom, $urandom, $urandom, $urandom};
      valid = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 2) != 0);
      clr   = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/aes_out_serializer.md
Name: aes_out_serializer

Overview:
- Sits directly downstream of the AES core and consumes its 128-bit result (AES_data_out / AES_data_out_valid).
- Captures each completed block into a small FIFO, then streams it out as WORD_W-bit words over a valid/ready handshake, most-significant word first.
- Flags blocks lost to back-pressure with a sticky overflow bit.

Parameters:
- WORD_W, 32, output word width; legal values 8/16/32/64; NUM_WORDS = 128/WORD_W.
- DEPTH, 2, number of 128-bit block entries in the FIFO; legal values 2..8.

Ports:
- AES_clk  in  1  clock, all logic on rising edge.
- AES_rst  in  1  reset, asynchronous, active-high.
- AES_data_out_valid  in  1  result-valid from the AES core; may stay high for several cycles.
- AES_data_out  in  128  result block from the AES core; stable while AES_data_out_valid is high.
- m_valid  out  1  output word valid.
- m_data  out  WORD_W  output word.
- m_last  out  1  high with the final word (index NUM_WORDS-1) of a block.
- m_ready  in  1  downstream accepts the word.
- ovf  out  1  sticky overflow: at least one block was dropped.
- clr_ovf  in  1  synchronous clear of ovf.
- buf_count  out  $clog2(DEPTH+1)  number of blocks held, including any partially sent block.

Behaviour:
- Reset (async assert, sync release): FIFO empty; buf_count=0; word index=0; valid-edge register=0; m_valid=0; m_data=0; m_last=0; ovf=0.
- Capture:
  - Registered prev_valid tracks AES_data_out_valid.
  - A capture event is AES_data_out_valid=1 and prev_valid=0, sampled at a clock edge. One block is captured per rising edge of valid, however long valid stays high.
  - On capture, AES_data_out is written at the FIFO tail.
- Output:
  - m_valid = (buf_count != 0), so m_valid rises in the cycle after the capture edge. Capture-to-first-word latency is 1 cycle.
  - m_data = head block word at the current index. Index 0 = bits[127:128-WORD_W]; index k = bits[127-k*WORD_W -: WORD_W].
  - m_data = 0 when the FIFO is empty.
  - m_last = m_valid && (index == NUM_WORDS-1).
- Transfer:
  - A transfer occurs on m_valid && m_ready at a clock edge.
  - Index increments on each transfer. When the transfer has m_last=1, index wraps to 0 and the head pops.
  - While m_valid=1 and m_ready=0, m_data, m_last and index hold.
- Simultaneous events:
  - Capture and pop in the same cycle: both happen; buf_count unchanged.
  - FIFO full, capture, and pop in the same cycle: the capture is accepted into the freed slot, and ovf is not set.
  - FIFO full, capture, no pop: the incoming block is dropped and ovf is set. FIFO contents, index and buf_count are unchanged.
  - ovf set and clr_ovf in the same cycle: set wins, ovf=1.
- Reset mid-stream: the partially sent block is discarded and m_valid falls immediately on reset assertion.
- FIFO pointers wrap modulo DEPTH. buf_count never exceeds DEPTH.
- No combinational path from m_ready to m_valid or m_data; m_ready affects only state.

Test Plan:
- Basic:
  - Stimulus: one capture of 128'h3925841d_02dc09fb_dc118597_196a0b32 with m_ready=1.
  - Response: starting the cycle after capture, words 3925841d, 02dc09fb, dc118597, 196a0b32 on 4 consecutive cycles; m_last only on the 4th; then m_valid=0 and buf_count=0.
- Long valid:
  - Stimulus: AES_data_out_valid held high for 10 cycles with a constant block.
  - Response: exactly one block (4 words) emitted; buf_count peaks at 1.
- Back-pressure:
  - Stimulus: m_ready toggles 1,0,0,1,0,1,1 during the same block.
  - Response: words appear in the correct order with no duplicates or skips; m_data is stable during m_ready=0 cycles.
- Overflow:
  - Stimulus: m_ready=0; capture blocks A=128'h1, B=128'h2, C=128'h3 (separate valid pulses), then m_ready=1.
  - Response: buf_count=2; ovf=1 after C; outputs are A then B only; clr_ovf pulse returns ovf to 0.
- Full + pop + capture:
  - Stimulus: FIFO full (DEPTH=2) and the last word of the head transfers in the same cycle as a new capture D.
  - Response: ovf stays 0; buf_count stays 2; D is emitted after the remaining block.
- Reset mid-block:
  - Stimulus: assert AES_rst asynchronously after 2 words of a block are sent.
  - Response: m_valid=0 and buf_count=0 immediately; after release, the next capture starts at word index 0.
